// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
// Serialises decode reads (two operands) and writeback writes onto the
// single-port control of the 32x32 RegisterFile. Writes win contention until
// MAX_WR_BURST consecutive write grants have starved a pending read. After that
// the read is forced through. Read operands are returned on a valid/ready
// response channel.
// Optional build macro: RF_R0_ZERO_EN. When it is defined, r0 is hard-wired
// to zero: writes to r0 are accepted but never reach the RegisterFile, and r0
// operands read back as 0.
module regfile_access_ctrl #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int MAX_WR_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rf_in,
    output logic [ADDR_W-1:0] rf_addr_a,
    output logic [ADDR_W-1:0] rf_addr_b,
    output logic              rf_rw,
    output logic              rf_sel,
    input  logic [DATA_W-1:0] rf_out_a,
    input  logic [DATA_W-1:0] rf_out_b
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CAPT, S_RSP} state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_WR_BURST);

    state_t                   state_q, state_d;
    logic [3:0]               burst_q, burst_d;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]        wr_data_q, wr_data_d;
    logic [1:0][ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [1:0][DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [1:0][DATA_W-1:0]   rf_out_lane;
    logic [1:0][DATA_W-1:0]   capt_lane;
    logic                     wr_grant, rd_grant;
    logic                     wr_block;

    assign rf_out_lane[0] = rf_out_a;
    assign rf_out_lane[1] = rf_out_b;

    // Per-operand capture value; r0 optionally reads as zero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
`ifdef RF_R0_ZERO_EN
            assign capt_lane[gi] = (rd_addr_q[gi] == '0) ? '0 : rf_out_lane[gi];
`else
            assign capt_lane[gi] = rf_out_lane[gi];
`endif
        end
    endgenerate

    // A write to r0 is swallowed by keeping the RegisterFile deselected.
`ifdef RF_R0_ZERO_EN
    assign wr_block = (wr_addr_q == '0);
`else
    assign wr_block = 1'b0;
`endif

    // Arbitration: grants only in IDLE and never while in reset.
    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (!rst && state_q == S_IDLE) begin
            if (wr_valid && (!rd_req_valid || burst_q < BURST_LIMIT)) begin
                wr_grant = 1'b1;
            end else if (rd_req_valid) begin
                rd_grant = 1'b1;
            end
        end
    end

    assign wr_ready     = wr_grant;
    assign rd_req_ready = rd_grant;

    // Next-state logic: sequencing, request latching, burst counting, capture.
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (wr_grant) begin
                    state_d   = S_WR;
                    wr_addr_d = wr_addr;
                    wr_data_d = wr_data;
                    burst_d   = rd_req_valid ? burst_q + 4'd1 : 4'd0;
                end else if (rd_grant) begin
                    state_d      = S_RD;
                    rd_addr_d[0] = rd_addr_a;
                    rd_addr_d[1] = rd_addr_b;
                    burst_d      = 4'd0;
                end
            end
            S_WR:    state_d = S_IDLE;
            S_RD:    state_d = S_CAPT;
            S_CAPT: begin
                // RegisterFile clears its outputs after this cycle, so grab them now.
                rd_data_d = capt_lane;
                state_d   = S_RSP;
            end
            S_RSP: begin
                if (rd_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            burst_q   <= 4'd0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // RegisterFile control and response outputs decoded from the current state.
    // Reset overrides the select so an access in flight never completes.
    always_comb begin
        rf_sel       = 1'b1;
        rf_rw        = 1'b1;
        rf_addr_a    = '0;
        rf_addr_b    = '0;
        rf_in        = '0;
        rd_rsp_valid = 1'b0;
        case (state_q)
            S_WR: begin
                rf_sel    = rst | wr_block;
                rf_rw     = rst;
                rf_addr_a = wr_addr_q;
                rf_in     = wr_data_q;
            end
            S_RD: begin
                rf_sel    = rst;
                rf_addr_a = rd_addr_q[0];
                rf_addr_b = rd_addr_q[1];
            end
            S_RSP:   rd_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rd_data_a = rd_data_q[0];
    assign rd_data_b = rd_data_q[1];

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a behavioural RegisterFile, a transaction-level
// scoreboard (register array + queue of expected operand pairs + arbitration
// rule), a directed vector table and hand-written corner sequences, then a
// randomized phase.
module tb_regfile_access_ctrl;

`ifdef RF_R0_ZERO_EN
    localparam bit R0EN = 1'b1;
`else
    localparam bit R0EN = 1'b0;
`endif
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req_valid = 1'b0, rd_req_ready;
    logic [4:0]  rd_addr_a = '0, rd_addr_b = '0;
    logic        rd_rsp_valid, rd_rsp_ready = 1'b1;
    logic [31:0] rd_data_a, rd_data_b;
    logic        wr_valid = 1'b0, wr_ready;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rf_in;
    logic [4:0]  rf_addr_a, rf_addr_b;
    logic        rf_rw, rf_sel;
    logic [31:0] rf_out_a, rf_out_b;

    regfile_access_ctrl dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rf_in(rf_in), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_rw(rf_rw), .rf_sel(rf_sel),
        .rf_out_a(rf_out_a), .rf_out_b(rf_out_b)
    );

    always #5 clk = ~clk;

    // Behavioural RegisterFile: registered outputs, cleared whenever deselected.
    logic [31:0] rf_mem [32];
    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        rf_out_a = '0;
        rf_out_b = '0;
    end
    always @(posedge clk) begin
        if (!rf_sel) begin
            if (!rf_rw) begin
                rf_mem[rf_addr_a] <= rf_in;
            end else begin
                rf_out_a <= rf_mem[rf_addr_a];
                rf_out_b <= rf_mem[rf_addr_b];
            end
        end else begin
            rf_out_a <= '0;
            rf_out_b <= '0;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state
    typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
    pair_t       exp_q[$];
    logic [31:0] model_mem [32];
    int          burst_cnt = 0;
    initial for (int i = 0; i < 32; i++) model_mem[i] = '0;

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (R0EN && a == 5'd0) return 32'd0;
        return model_mem[a];
    endfunction

    // Snapshot of DUT outputs taken at the falling edge
    logic        s_wr_ready, s_rd_req_ready, s_rsp_valid, s_rf_sel, s_rf_rw;
    logic [31:0] s_data_a, s_data_b, s_rf_in;
    logic [4:0]  s_rf_addr_a, s_rf_addr_b;

    task automatic scoreboard();
        pair_t p;
        if (rst) begin
            exp_q.delete();
            burst_cnt = 0;
            return;
        end
        if (s_wr_ready || s_rd_req_ready)
            chk("ready_needs_valid", 32'((s_wr_ready && !wr_valid) || (s_rd_req_ready && !rd_req_valid)), 32'd0);
        if (wr_valid && rd_req_valid && (s_wr_ready || s_rd_req_ready))
            chk("arb_write_wins", 32'(s_wr_ready), 32'(burst_cnt < MAXB));
        if (wr_valid && s_wr_ready) begin
            if (!(R0EN && wr_addr == 5'd0)) model_mem[wr_addr] = wr_data;
            burst_cnt = rd_req_valid ? burst_cnt + 1 : 0;
        end
        if (rd_req_valid && s_rd_req_ready) begin
            p.a = model_rd(rd_addr_a);
            p.b = model_rd(rd_addr_b);
            exp_q.push_back(p);
            burst_cnt = 0;
        end
        if (s_rsp_valid && rd_rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_without_request", 32'd1, 32'd0);
            end else begin
                p = exp_q.pop_front();
                chk("rsp_data_a", s_data_a, p.a);
                chk("rsp_data_b", s_data_b, p.b);
            end
        end
    endtask

    // One clock: sample at negedge, score it, then return just after posedge.
    task automatic tick();
        @(negedge clk);
        s_wr_ready     = wr_ready;
        s_rd_req_ready = rd_req_ready;
        s_rsp_valid    = rd_rsp_valid;
        s_data_a       = rd_data_a;
        s_data_b       = rd_data_b;
        s_rf_sel       = rf_sel;
        s_rf_rw        = rf_rw;
        s_rf_in        = rf_in;
        s_rf_addr_a    = rf_addr_a;
        s_rf_addr_b    = rf_addr_b;
        scoreboard();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic exp_sel);
        int n = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        do begin tick(); n++; end while (!s_wr_ready && n < 20);
        chk("wr_accept", 32'(s_wr_ready), 32'd1);
        wr_valid = 1'b0;
        tick();
        chk("wr_cycle_sel", 32'(s_rf_sel), 32'(exp_sel));
        chk("wr_cycle_rw", 32'(s_rf_rw), 32'd0);
        chk("wr_cycle_addr", 32'(s_rf_addr_a), 32'(a));
        chk("wr_cycle_in", s_rf_in, d);
        $display("write r%0d = %h", a, d);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                           input logic [31:0] ea, input logic [31:0] eb);
        int n = 0;
        rd_rsp_ready = 1'b1;
        rd_req_valid = 1'b1; rd_addr_a = a; rd_addr_b = b;
        do begin tick(); n++; end while (!s_rd_req_ready && n < 20);
        chk("rd_accept", 32'(s_rd_req_ready), 32'd1);
        rd_req_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!s_rsp_valid && n < 20);
        chk("rd_latency", 32'(n), 32'd3);
        chk("rd_data_a", s_data_a, ea);
        chk("rd_data_b", s_data_b, eb);
        $display("read r%0d r%0d -> %h %h", a, b, s_data_a, s_data_b);
    endtask

    typedef struct {
        bit          is_wr;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] data;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        bit          exp_sel;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n, wcount, rd_after;
        vecs[0] = '{1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 5'd5,  5'd0,  32'h0, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0, 32'h0, R0EN};
        vecs[3] = '{1'b0, 5'd0,  5'd5,  32'h0, (R0EN ? 32'h0 : 32'hFFFFFFFF), 32'hDEADBEEF, 1'b0};
        vecs[4] = '{1'b1, 5'd7,  5'd0,  32'h00000001, 32'h0, 32'h0, 1'b0};
        vecs[5] = '{1'b1, 5'd31, 5'd0,  32'hA5A5A5A5, 32'h0, 32'h0, 1'b0};
        vecs[6] = '{1'b0, 5'd31, 5'd7,  32'h0, 32'hA5A5A5A5, 32'h00000001, 1'b0};
        vecs[7] = '{1'b0, 5'd7,  5'd31, 32'h0, 32'h00000001, 32'hA5A5A5A5, 1'b0};

        // Reset: no handshakes while rst is high, outputs at reset values
        rst = 1'b1; wr_valid = 1'b1; rd_req_valid = 1'b1;
        tick();
        tick();
        chk("rst_wr_ready", 32'(s_wr_ready), 32'd0);
        chk("rst_rd_req_ready", 32'(s_rd_req_ready), 32'd0);
        wr_valid = 1'b0; rd_req_valid = 1'b0; rst = 1'b0;
        tick();
        chk("reset_rf_sel", 32'(s_rf_sel), 32'd1);
        chk("reset_rf_rw", 32'(s_rf_rw), 32'd1);
        chk("reset_rf_addr", {22'd0, s_rf_addr_a, s_rf_addr_b}, 32'd0);
        chk("reset_rf_in", s_rf_in, 32'd0);
        chk("reset_rsp_valid", 32'(s_rsp_valid), 32'd0);
        chk("reset_rd_data", s_data_a | s_data_b, 32'd0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].data, vecs[i].exp_sel);
            else               do_read(vecs[i].a, vecs[i].b, vecs[i].exp_a, vecs[i].exp_b);
        end

        // Same-cycle read and write to r7: write first, read sees new value
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        rd_req_valid = 1'b1; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        tick();
        chk("same_cycle_wr_first", {30'd0, s_wr_ready, s_rd_req_ready}, 32'd2);
        wr_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!s_rd_req_ready && n < 20);
        chk("same_cycle_rd_accept", 32'(s_rd_req_ready), 32'd1);
        rd_req_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!s_rsp_valid && n < 20);
        chk("same_cycle_rd_data", s_data_a, 32'h12345678);
        $display("same-cycle r7 read -> %h", s_data_a);

        // Write burst against a pending read
        rd_rsp_ready = 1'b1;
        rd_req_valid = 1'b1; rd_addr_a = 5'd8; rd_addr_b = 5'd9;
        wr_valid = 1'b1; wr_addr = 5'd8; wr_data = $urandom;
        wcount = 0; rd_after = -1;
        for (int c = 0; c < 100 && (wcount < 8 || rd_after < 0); c++) begin
            tick();
            if (s_wr_ready) begin
                wcount++;
                if (wcount == 8) wr_valid = 1'b0;
                else begin wr_addr = 5'(8 + wcount); wr_data = $urandom; end
            end
            if (s_rd_req_ready && rd_req_valid) begin
                rd_after = wcount;
                rd_req_valid = 1'b0;
            end
        end
        chk("burst_read_after_writes", 32'(rd_after), 32'(MAXB));
        chk("burst_writes_resume", 32'(wcount), 32'd8);
        $display("burst: read granted after %0d writes, %0d writes total", rd_after, wcount);
        for (int c = 0; c < 4; c++) tick();

        // Response back-pressure: held stable, no grants, RegisterFile idle
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b1; rd_addr_a = 5'd31; rd_addr_b = 5'd7;
        n = 0;
        do begin tick(); n++; end while (!s_rd_req_ready && n < 20);
        rd_req_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!s_rsp_valid && n < 20);
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h0BADF00D;
        rd_req_valid = 1'b1; rd_addr_a = 5'd1; rd_addr_b = 5'd2;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_rsp_valid", 32'(s_rsp_valid), 32'd1);
            chk("stall_data_a", s_data_a, 32'hA5A5A5A5);
            chk("stall_data_b", s_data_b, 32'h12345678);
            chk("stall_no_grant", {30'd0, s_wr_ready, s_rd_req_ready}, 32'd0);
            chk("stall_rf_sel", 32'(s_rf_sel), 32'd1);
        end
        wr_valid = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
        tick();
        tick();
        chk("stall_release", 32'(s_rsp_valid), 32'd0);
        $display("stall: response held 5 cycles then released");

        // Reset during the RD cycle abandons the read
        rd_req_valid = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        n = 0;
        do begin tick(); n++; end while (!s_rd_req_ready && n < 20);
        rd_req_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_in_rd_sel", 32'(s_rf_sel), 32'd1);
        rst = 1'b0;
        tick();
        chk("rst_rd_rsp_valid", 32'(s_rsp_valid), 32'd0);
        chk("rst_rd_rf_sel_rw", {30'd0, s_rf_sel, s_rf_rw}, 32'd3);
        chk("rst_rd_rf_addr", {22'd0, s_rf_addr_a, s_rf_addr_b}, 32'd0);
        chk("rst_rd_rf_in", s_rf_in, 32'd0);
        chk("rst_rd_data", s_data_a | s_data_b, 32'd0);
        n = 0;
        for (int c = 0; c < 4; c++) begin tick(); if (s_rsp_valid) n++; end
        chk("rst_rd_abandoned", 32'(n), 32'd0);
        $display("reset in RD: read abandoned");

        // Randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            rd_rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (!wr_valid || s_wr_ready) begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_addr  = 5'($urandom_range(0, 31));
                wr_data  = $urandom;
            end
            if (!rd_req_valid || s_rd_req_ready) begin
                rd_req_valid = 1'($urandom_range(0, 1));
                rd_addr_a    = 5'($urandom_range(0, 31));
                rd_addr_b    = 5'($urandom_range(0, 31));
            end
        end
        wr_valid = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk("random_drained", 32'(exp_q.size()), 32'd0);
        $display("random phase complete");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Sequences all accesses to the 32x32 RegisterFile, whose single write/read control (rw, active-low sel) allows only one operation per cycle.
- Arbitrates between one read requester (decode: two source addresses) and one write requester (writeback: one destination).
- Drives the RegisterFile control, address and data lines, and returns captured operand pairs through a valid/ready response.
- Sits between decode/writeback and the RegisterFile instance.

Parameters:
- DATA_W, 32, data width; matches RegisterFile.
- ADDR_W, 5, register address width.
- MAX_WR_BURST, 4, maximum consecutive write grants while a read is pending before the read is forced through (range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- rd_req_valid  in  1  read request present.
- rd_req_ready  out  1  read request accepted this cycle.
- rd_addr_a  in  ADDR_W  first source register.
- rd_addr_b  in  ADDR_W  second source register.
- rd_rsp_valid  out  1  operand pair valid.
- rd_rsp_ready  in  1  consumer takes the operand pair.
- rd_data_a  out  DATA_W  operand A.
- rd_data_b  out  DATA_W  operand B.
- wr_valid  in  1  write request present.
- wr_ready  out  1  write request accepted this cycle.
- wr_addr  in  ADDR_W  destination register.
- wr_data  in  DATA_W  write data.
- rf_in  out  DATA_W  to RegisterFile in_reg.
- rf_addr_a  out  ADDR_W  to addr_a (write address or read address A).
- rf_addr_b  out  ADDR_W  to addr_b.
- rf_rw  out  1  to rw (1 = read, 0 = write).
- rf_sel  out  1  to sel, active low.
- rf_out_a  in  DATA_W  from out_a.
- rf_out_b  in  DATA_W  from out_b.

Behaviour:
Reset
- Single clock clk; reset rst is synchronous and active-high.
- Reset state: IDLE.
- Output reset values: rf_sel=1, rf_rw=1, rf_addr_a=0, rf_addr_b=0, rf_in=0, rd_rsp_valid=0, rd_data_a=0, rd_data_b=0, burst counter=0.
- rd_req_ready and wr_ready are 0 while rst=1.

FSM states: IDLE, WR, RD, CAPT, RSP
- Handshakes are asserted only in IDLE, combinationally from the valid inputs.
- IDLE grant when both valid: write wins if burst counter < MAX_WR_BURST, otherwise read wins.
- IDLE grant when one valid: that requester wins.
- On grant, latch the request's addresses/data and go to WR or RD.
- Burst counter increments on a write grant while rd_req_valid=1. It clears on any read grant, and on a write grant with rd_req_valid=0.
- WR (1 cycle): rf_sel=0, rf_rw=0, rf_addr_a=latched wr_addr, rf_in=latched wr_data. Next state IDLE. Data is in the RegisterFile at the end of this cycle.
- RD (1 cycle): rf_sel=0, rf_rw=1, rf_addr_a/b = latched read addresses. The RegisterFile registers out_a/out_b at the end of this cycle. Next state CAPT.
- CAPT (1 cycle): rf_sel=1. Latch rf_out_a/rf_out_b into rd_data_a/b, since the RegisterFile clears its outputs at the end of this cycle. Next state RSP.
- RSP: rd_rsp_valid=1; rd_data_a/b held stable. When rd_rsp_ready=1, go to IDLE with rd_rsp_valid=0 next cycle. No new grant is given while in RSP.
- In all states other than WR/RD: rf_sel=1, rf_rw=1.

Latency and ordering
- Read: accept at cycle T, rd_rsp_valid at T+3; minimum 4 cycles per read.
- Write: accept at T, RegisterFile written at the end of T+1; 2 cycles per write.
- A read accepted at or after T+2 returns the new value.
- Same-cycle read and write to the same register: the write is granted first (when burst permits), so the read returns the new value.
- Requesters must hold valid and payload stable until ready.
- rst mid-operation: the operation is abandoned and the FSM returns to IDLE. A write in WR with rst=1 still drives rf_sel=1, so no write occurs.

Optional Feature:
- Macro: RF_R0_ZERO_EN.
- Defined:
  - Writes to address 0 are accepted (wr_ready as normal), but WR drives rf_sel=1, so r0 is never written.
  - In CAPT, the operand for an address equal to 0 is forced to 0 regardless of rf_out.
- Undefined: r0 is an ordinary register.

Test Plan:
1. rst, write r5=0xDEADBEEF, then read a=5 b=0 -> wr_ready at T, rf_sel=0/rf_rw=0 at T+1; read rd_rsp_valid 3 cycles after accept, rd_data_a=0xDEADBEEF.
2. Read and write r7=0x12345678 valid in the same cycle, r7 previously 0x1 -> write granted first; read returns 0x12345678.
3. wr_valid held high with 8 back-to-back writes plus a pending read, MAX_WR_BURST=4 -> read granted after exactly 4 write grants, then writes resume.
4. rd_rsp_ready held 0 for 5 cycles -> rd_rsp_valid and data stable, no further grants, rf_sel=1 throughout.
5. rst asserted in the RD cycle -> next cycle IDLE, rd_rsp_valid=0, all rf outputs at reset values.
6. RF_R0_ZERO_EN defined: write r0=0xFFFFFFFF, then read a=0 -> rf_sel stays 1 in WR, rd_data_a=0. Undefined: rd_data_a=0xFFFFFFFF.
